// File: rtl/tri_fetch_stream.sv
// tri_fetch_stream: walks one object's triangle list in a fixed-latency BRAM
// and emits assembled triangles (normal + three vertices) over valid/ready.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for go; latches count and issues the first row
// S_RUN  | issuing rows, assembling triangles, until last handshake
// S_DONE | single cycle with obj_done high, then back to S_IDLE
module tri_fetch_stream #(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 12,
  parameter int COUNT_W     = 10,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          go,
  input  logic [ADDR_W-1:0]             base_addr_in,
  input  logic [COUNT_W-1:0]            tri_count_in,
  output logic [ADDR_W-1:0]             mem_addr_out,
  output logic                          mem_en_out,
  input  logic [3*WIDTH-1:0]            mem_data_in,
  output logic [3:0][2:0][WIDTH-1:0]    tri_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [COUNT_W-1:0]            tri_index_out,
  output logic                          obj_done,
  output logic                          busy_out
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ROWS_W = COUNT_W + 2;
  localparam int CRED_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 2) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [COUNT_W-1:0]          count_q, count_d;
  logic [ROWS_W-1:0]           rows_q, rows_d;
  logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
  logic                        mem_en_q, mem_en_d;
  logic [ROM_LATENCY-1:0]      inflt_q, inflt_d;

  logic [3*WIDTH-1:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]            occ_q, occ_d;

  logic [1:0]                  slot_q, slot_d;
  logic [2:0][3*WIDTH-1:0]     hold_q, hold_d;
  logic [3:0][2:0][WIDTH-1:0]  tri_q, tri_d;
  logic                        valid_q, valid_d;
  logic [COUNT_W-1:0]          idx_q, idx_d;
  logic [COUNT_W-1:0]          loaded_q, loaded_d;

  logic                        go_acc;
  logic                        push;
  logic                        pop;
  logic                        load;
  logic                        fifo_empty;
  logic                        last_hs;
  logic                        can_issue;
  logic [3*WIDTH-1:0]          head;
  logic [CRED_W-1:0]           inflight;
  logic [CRED_W-1:0]           cred_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign go_acc     = (state_q == S_IDLE) && go;
  assign push       = inflt_q[ROM_LATENCY-1];
  assign fifo_empty = (occ_q == '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign pop        = !fifo_empty && ((slot_q != 2'd3) || !valid_q || ready_in);
  assign load       = pop && (slot_q == 2'd3);
  assign last_hs    = (state_q == S_RUN) && valid_q && ready_in &&
                      (idx_q == count_q - COUNT_W'(1));

  // Rows issued but not yet in the FIFO: the address register plus the latency pipe.
  always_comb begin
    inflight = CRED_W'(mem_en_q);
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + CRED_W'(inflt_q[i]);
    end
  end

  assign cred_used = inflight + CRED_W'(occ_q);
  assign can_issue = (rows_q < {count_q, 2'b00}) && (cred_used < CRED_W'(FIFO_DEPTH));

  // FSM next state and row issue; the first row goes out on the go cycle itself.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rows_d     = rows_q;
    mem_addr_d = mem_addr_q;
    mem_en_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          count_d = tri_count_in;
          rows_d  = '0;
          if (tri_count_in == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_RUN;
            mem_en_d   = 1'b1;
            mem_addr_d = base_addr_in;
            rows_d     = ROWS_W'(1);
          end
        end
      end
      S_RUN: begin
        if (can_issue) begin
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
          rows_d     = rows_q + 1'b1;
        end
        if (last_hs) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valid pipe tracking outstanding reads; its tail marks returning data.
  always_comb begin
    inflt_d[0] = mem_en_q;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      inflt_d[i] = inflt_q[i-1];
    end
  end

  // FIFO pointer and occupancy updates.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
  end

  // Triangle assembly: slots 0..2 park rows, slot 3 loads the output register.
  always_comb begin
    slot_d   = slot_q;
    hold_d   = hold_q;
    tri_d    = tri_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    loaded_d = loaded_q;
    if (valid_q && ready_in) valid_d = 1'b0;
    if (pop) begin
      slot_d = slot_q + 2'd1;
      case (slot_q)
        2'd0:    hold_d[0] = head;
        2'd1:    hold_d[1] = head;
        2'd2:    hold_d[2] = head;
        default: begin
          tri_d    = {head, hold_q};
          valid_d  = 1'b1;
          idx_d    = loaded_q;
          loaded_d = loaded_q + 1'b1;
        end
      endcase
    end
    if (go_acc) loaded_d = '0;
  end

  // Control, issue and FIFO bookkeeping registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rows_q     <= '0;
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
      inflt_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rows_q     <= rows_d;
      mem_addr_q <= mem_addr_d;
      mem_en_q   <= mem_en_d;
      inflt_q    <= inflt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Row storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_data_in;
  end

  // Assembly slots and output register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_q   <= '0;
      hold_q   <= '0;
      tri_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      loaded_q <= '0;
    end else begin
      slot_q   <= slot_d;
      hold_q   <= hold_d;
      tri_q    <= tri_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
    end
  end

  assign mem_addr_out  = mem_addr_q;
  assign mem_en_out    = mem_en_q;
  assign tri_out       = tri_q;
  assign valid_out     = valid_q;
  assign tri_index_out = idx_q;
  assign obj_done      = (state_q == S_DONE);
  assign busy_out      = (state_q != S_IDLE);

  // Credits must keep the row FIFO within bounds.
  a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(push && !pop && (occ_q == OCC_W'(FIFO_DEPTH))));
  a_no_underflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(pop && fifo_empty));

endmodule

// File: tb/tb_tri_fetch_stream.sv
// Bench for tri_fetch_stream: three instances at ROM latency 1, 2 and 3 share
// go/base/count/reset; each has its own ready and its own memory model.
module tb_tri_fetch_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        go;
  logic [11:0] base_in;
  logic [9:0]  cnt_in;

  logic                   rdy   [3];
  logic [11:0]            maddr [3];
  logic                   men   [3];
  logic [3:0][2:0][31:0]  tri_o [3];
  logic                   vld   [3];
  logic [9:0]             idx   [3];
  logic                   done  [3];
  logic                   busy  [3];

  int total = 0;
  int bad   = 0;

  function automatic logic [95:0] row_f(input logic [11:0] r);
    return {32'(r) + 32'd2, 32'(r) + 32'd1, 32'(r)};
  endfunction

  function automatic logic [383:0] exp_tri(input logic [11:0] b, input int k);
    logic [383:0] t;
    logic [11:0]  r;
    t = '0;
    for (int j = 0; j < 4; j++) begin
      r = b + 12'(4 * k + j);
      t[j*96 +: 96] = row_f(r);
    end
    return t;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [95:0] pipe [g+1];
    always @(posedge clk) begin
      pipe[0] <= row_f(maddr[g]);
      for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
    end
    tri_fetch_stream #(
      .WIDTH(32), .ADDR_W(12), .COUNT_W(10), .ROM_LATENCY(g + 1), .FIFO_DEPTH(8)
    ) u_dut (
      .clk_in(clk), .rst_in(rst), .go(go),
      .base_addr_in(base_in), .tri_count_in(cnt_in),
      .mem_addr_out(maddr[g]), .mem_en_out(men[g]), .mem_data_in(pipe[g]),
      .tri_out(tri_o[g]), .valid_out(vld[g]), .ready_in(rdy[g]),
      .tri_index_out(idx[g]), .obj_done(done[g]), .busy_out(busy[g])
    );
  end

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rdy(input logic v);
    for (int g = 0; g < 3; g++) rdy[g] = v;
  endtask

  task automatic idle(input int n);
    set_rdy(1'b1);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_addr_L%0d", tag, g + 1), 384'(maddr[g]), 384'(0));
      chk($sformatf("%s_en_L%0d", tag, g + 1), 384'(men[g]), 384'(0));
      chk($sformatf("%s_tri_L%0d", tag, g + 1), 384'(tri_o[g]), 384'(0));
      chk($sformatf("%s_valid_L%0d", tag, g + 1), 384'(vld[g]), 384'(0));
      chk($sformatf("%s_idx_L%0d", tag, g + 1), 384'(idx[g]), 384'(0));
      chk($sformatf("%s_done_L%0d", tag, g + 1), 384'(done[g]), 384'(0));
      chk($sformatf("%s_busy_L%0d", tag, g + 1), 384'(busy[g]), 384'(0));
    end
  endtask

  // Scoreboard state shared by the multi-cycle sequences.
  logic [11:0] sb_base;
  int k_exp  [3];
  int ndone  [3];
  int issued [3];

  task automatic sb_start(input logic [11:0] b);
    sb_base = b;
    for (int g = 0; g < 3; g++) begin
      k_exp[g]  = 0;
      ndone[g]  = 0;
      issued[g] = 0;
    end
  endtask

  // Observe the current cycle (ready already driven), then advance one clock.
  task automatic sb_step();
    for (int g = 0; g < 3; g++) begin
      if (done[g]) ndone[g]++;
      if (men[g]) issued[g]++;
      if (vld[g] && rdy[g]) begin
        chk($sformatf("tri%0d_L%0d", k_exp[g], g + 1), 384'(tri_o[g]), exp_tri(sb_base, k_exp[g]));
        chk($sformatf("idx%0d_L%0d", k_exp[g], g + 1), 384'(idx[g]), 384'(k_exp[g]));
        k_exp[g]++;
      end
    end
    cyc();
  endtask

  task automatic start(input logic [11:0] b, input logic [9:0] n);
    base_in = b;
    cnt_in  = n;
    go      = 1'b1;
    cyc();
    go      = 1'b0;
  endtask

  task automatic sb_run(input bit rnd, input int maxc, input int n);
    int post;
    post = 0;
    for (int c = 0; c < maxc && post < 4; c++) begin
      for (int g = 0; g < 3; g++) rdy[g] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sb_step();
      if (ndone[0] > 0 && ndone[1] > 0 && ndone[2] > 0) post++;
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("ntri_L%0d", g + 1), 384'(k_exp[g]), 384'(n));
      chk($sformatf("ndone_L%0d", g + 1), 384'(ndone[g]), 384'(1));
    end
    set_rdy(1'b1);
  endtask

  typedef struct {
    logic        go;
    logic        en;
    logic [11:0] addr;
    logic        vld;
    logic [9:0]  idx;
    logic        done;
    logic        busy;
  } vec_t;

  initial begin
    vec_t tbl [15];
    logic [11:0] wrap_a [4];
    logic [383:0] ft;
    logic [9:0]   fi;
    int c;

    // Basic run at latency 2: base 0x010, two triangles, ready held high.
    //          go    en    addr     vld   idx    done  busy
    tbl[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 10'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 12'h010, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 12'h011, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 12'h012, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 12'h013, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 12'h014, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 12'h015, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 12'h016, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 12'h017, 1'b1, 10'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 12'h000, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 12'h000, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 12'h000, 1'b0, 10'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 12'h000, 1'b1, 10'd1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 12'h000, 1'b0, 10'd0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 12'h000, 1'b0, 10'd0, 1'b0, 1'b0};

    wrap_a[0] = 12'hFFE;
    wrap_a[1] = 12'hFFF;
    wrap_a[2] = 12'h000;
    wrap_a[3] = 12'h001;

    rst = 1'b1; go = 1'b0; base_in = '0; cnt_in = '0;
    set_rdy(1'b1);
    @(negedge clk);
    cyc(); cyc();
    chk_zero("reset");
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 15; i++) begin
      go = tbl[i].go; base_in = 12'h010; cnt_in = 10'd2;
      chk($sformatf("basic_en_c%0d", i), 384'(men[1]), 384'(tbl[i].en));
      if (tbl[i].en) chk($sformatf("basic_addr_c%0d", i), 384'(maddr[1]), 384'(tbl[i].addr));
      chk($sformatf("basic_valid_c%0d", i), 384'(vld[1]), 384'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("basic_idx_c%0d", i), 384'(idx[1]), 384'(tbl[i].idx));
        chk($sformatf("basic_tri_c%0d", i), 384'(tri_o[1]), exp_tri(12'h010, int'(tbl[i].idx)));
      end
      chk($sformatf("basic_done_c%0d", i), 384'(done[1]), 384'(tbl[i].done));
      chk($sformatf("basic_busy_c%0d", i), 384'(busy[1]), 384'(tbl[i].busy));
      cyc();
    end
    go = 1'b0;
    idle(6);

    // Address wrap at the top of the 12-bit space.
    sb_start(12'hFFE);
    start(12'hFFE, 10'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_en_%0d", i), 384'(men[1]), 384'(1));
      chk($sformatf("wrap_addr_%0d", i), 384'(maddr[1]), 384'(wrap_a[i]));
      sb_step();
    end
    sb_run(1'b0, 100, 1);
    idle(4);

    // Backpressure: ready low for 20 cycles once the latency-2 output is valid.
    sb_start(12'h100);
    start(12'h100, 10'd5);
    for (c = 0; c < 40 && !vld[1]; c++) sb_step();
    chk("bp_first_valid", 384'(vld[1]), 384'(1));
    set_rdy(1'b0);
    ft = 384'(tri_o[1]);
    fi = idx[1];
    for (int i = 0; i < 20; i++) begin
      sb_step();
      chk($sformatf("bp_tri_frozen_%0d", i), 384'(tri_o[1]), ft);
      chk($sformatf("bp_idx_frozen_%0d", i), 384'(idx[1]), 384'(fi));
      chk($sformatf("bp_valid_held_%0d", i), 384'(vld[1]), 384'(1));
    end
    chk("bp_issue_limit", 384'(issued[1] <= 15), 384'(1));
    chk("bp_issue_stalled", 384'(men[1]), 384'(0));
    sb_run(1'b0, 200, 5);
    idle(4);

    // Zero count: only a done pulse in cycle 1.
    start(12'h050, 10'd0);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("zero_done1_L%0d", g + 1), 384'(done[g]), 384'(1));
      chk($sformatf("zero_busy1_L%0d", g + 1), 384'(busy[g]), 384'(1));
      chk($sformatf("zero_en1_L%0d", g + 1), 384'(men[g]), 384'(0));
      chk($sformatf("zero_valid1_L%0d", g + 1), 384'(vld[g]), 384'(0));
    end
    cyc();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("zero_done2_L%0d", g + 1), 384'(done[g]), 384'(0));
      chk($sformatf("zero_busy2_L%0d", g + 1), 384'(busy[g]), 384'(0));
      chk($sformatf("zero_en2_L%0d", g + 1), 384'(men[g]), 384'(0));
    end
    idle(3);

    // A second go while running must not disturb the address sequence.
    sb_start(12'h200);
    start(12'h200, 10'd2);
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) begin
        base_in = 12'h300; cnt_in = 10'd7; go = 1'b1;
      end else begin
        go = 1'b0;
      end
      chk($sformatf("gobusy_en_c%0d", i), 384'(men[1]), 384'(1));
      chk($sformatf("gobusy_addr_c%0d", i), 384'(maddr[1]), 384'(12'h200 + 12'(i - 1)));
      sb_step();
    end
    go = 1'b0;
    sb_run(1'b0, 100, 2);
    idle(4);

    // Reset while the third triangle sits on the latency-2 output.
    sb_start(12'h040);
    start(12'h040, 10'd5);
    for (c = 0; c < 80 && !(vld[1] && idx[1] == 10'd2); c++) sb_step();
    chk("rst_reached_tri2", 384'(vld[1] && idx[1] == 10'd2), 384'(1));
    rst = 1'b1;
    cyc();
    chk_zero("midrst");
    rst = 1'b0;
    idle(1);
    sb_start(12'h080);
    start(12'h080, 10'd1);
    sb_run(1'b0, 60, 1);
    idle(4);

    // Random ready on all three latencies, 50 triangles each.
    sb_start(12'hF00);
    start(12'hF00, 10'd50);
    sb_run(1'b1, 4000, 50);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
